e_mudi: RTL and testbench

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations issued from E and holds the HI/LO architectural registers. It drives `busy` to the hazard unit, which stalls any mult/div-class instruction in D while `busy` is high or such an instruction occupies E. It returns mfhi/mflo read data into the E-stage result path.

---
 rtl/mudi_pkg.sv | 29 ++
 rtl/mudi_sdiv.sv | 33 +++
 rtl/e_mudi.sv | 114 +++++++++++
 tb/tb_e_mudi.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mudi_pkg.sv
// Shared op codes, default cycle counts and result type for the multiply/divide unit.
// Also used by the hazard decoder to classify calmudi/readhl/writehl instructions.
package mudi_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mudi_sdiv.sv
// Combinational 32-bit signed/unsigned divider: quotient truncates toward zero,
// remainder takes the dividend's sign. Divide by zero yields 0/0 (caller discards it).
module mudi_sdiv (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] uq, ur;

  assign a_neg = signed_i & a_i[31];
  assign b_neg = signed_i & b_i[31];
  assign a_mag = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag = b_neg ? (~b_i + 32'd1) : b_i;

  always_comb begin
    uq = '0;
    ur = '0;
    if (b_mag != 32'd0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
  end

  // INT_MIN/-1: magnitude 0x80000000 fits unsigned, same-sign quotient stays 0x80000000.
  assign quo_o = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem_o = a_neg ? (~ur + 32'd1) : ur;

endmodule

// File: rtl/e_mudi.sv
// E-stage mult/div sequencer: latches the result at issue, holds busy for a fixed
// count, commits HI/LO as busy falls. mt/mf ops act at zero latency; start while busy is ignored.
module e_mudi
  import mudi_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic               busy,
  output logic [31:0]        HI,
  output logic [31:0]        LO,
  output logic [31:0]        md_out
);

  localparam int CNT_W = $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  hilo_t            res_q, res_d;
  logic             wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] quo, rem;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  mudi_sdiv u_sdiv (
    .a_i      (A),
    .b_i      (B),
    .signed_i (md_op == MD_DIV),
    .quo_o    (quo),
    .rem_o    (rem)
  );

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    res_d = res_q;
    wr_d  = wr_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && wr_q) begin
        hi_d = res_q.hi;
        lo_d = res_q.lo;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT: begin
          res_d = hilo_t'(prod_s);
          wr_d  = 1'b1;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MD_MULTU: begin
          res_d = hilo_t'(prod_u);
          wr_d  = 1'b1;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          res_d.hi = rem;
          res_d.lo = quo;
          // Divide by zero still occupies the unit but leaves HI/LO alone.
          wr_d  = (B != 32'd0);
          cnt_d = CNT_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: ;
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      res_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      res_q  <= res_d;
      wr_q   <= wr_d;
    end
  end

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi_q;
      MD_MFLO: md_out = lo_q;
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mudi.sv
// Bench for e_mudi: directed scenarios plus random ops against an arithmetic HI/LO model.
module tb_e_mudi;
  import mudi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, md_out;

  int tests = 0;
  int fails = 0;
  int viol_cnt = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_mudi dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1 && busy === 1'b1) begin
      viol_cnt++;
      $display("[TB] note: start asserted while busy at %0t (protocol violation)", $time);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // Architectural effect of one op, from plain 64-bit integer arithmetic.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_DIV:   if (b != 0) begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
      MD_DIVU:  if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      MD_MTHI:  m_hi = a;
      MD_MTLO:  m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [3:0] op);
    if (op == MD_MULT || op == MD_MULTU) return 5;
    if (op == MD_DIV || op == MD_DIVU) return 10;
    return 0;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    bit done;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    ncyc = 0; done = 0; mid_hi = 'x; mid_lo = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin done = 1; break; end
      if (ncyc == 0) begin mid_hi = HI; mid_lo = LO; end
      ncyc++;
    end
    if (!done) ncyc = -1;
  endtask

  task automatic run_checked(input string name, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [31:0] mh, ml, old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    do_op(op, a, b, n, mh, ml);
    model_apply(op, a, b);
    tests++;
    if (n !== exp_cycles(op)) begin
      fails++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, exp_cycles(op));
    end
    if (exp_cycles(op) > 0) begin
      tests++;
      if (mh !== old_hi || ml !== old_lo) begin
        fails++; $display("FAIL %s hold_while_busy got %h/%h want %h/%h", name, mh, ml, old_hi, old_lo);
      end
    end
    tests++;
    if (HI !== m_hi || LO !== m_lo) begin
      fails++; $display("FAIL %s hilo got %h/%h want %h/%h", name, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; md_op = MD_MFHI; A = '0; B = '0;
    #3;
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || md_out !== 32'd0) begin
      fails++; $display("FAIL reset busy/HI/LO/md_out got %b/%h/%h/%h want 0/0/0/0", busy, HI, LO, md_out);
    end
    @(posedge clk); #1;
    reset = 1'b0; md_op = MD_NONE;
  endtask

  task automatic test_mult;
    run_checked("mult_neg2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    tests++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      fails++; $display("FAIL mult_const got %h/%h want ffffffff/fffffffa", HI, LO);
    end
    run_checked("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tests++;
    if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
      fails++; $display("FAIL multu_const got %h/%h want fffffffe/00000001", HI, LO);
    end
  endtask

  task automatic test_div;
    run_checked("div_neg7by2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    tests++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      fails++; $display("FAIL div_const got %h/%h want ffffffff/fffffffd", HI, LO);
    end
    run_checked("div_intmin", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tests++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      fails++; $display("FAIL div_intmin_const got %h/%h want 00000000/80000000", HI, LO);
    end
    run_checked("divu_big", MD_DIVU, 32'hFFFF_FFF9, 32'd2);
  endtask

  task automatic test_div_zero_and_mf;
    run_checked("mthi", MD_MTHI, 32'h0000_1234, 32'd0);
    run_checked("mtlo", MD_MTLO, 32'h0000_5678, 32'd0);
    run_checked("divu_by0", MD_DIVU, 32'd77, 32'd0);
    md_op = MD_MFLO; #1;
    tests++;
    if (md_out !== 32'h0000_5678) begin
      fails++; $display("FAIL mflo got %h want 00005678", md_out);
    end
    md_op = MD_MFHI; #1;
    tests++;
    if (md_out !== 32'h0000_1234) begin
      fails++; $display("FAIL mfhi got %h want 00001234", md_out);
    end
    md_op = MD_MULT; #1;
    tests++;
    if (md_out !== 32'd0) begin
      fails++; $display("FAIL md_out_other_op got %h want 0", md_out);
    end
    md_op = MD_NONE;
    run_checked("op_code_12", 4'd12, 32'hCAFE_0000, 32'd5);
  endtask

  task automatic test_reset_mid;
    run_checked("mthi_pre", MD_MTHI, 32'hAAAA_5555, 32'd0);
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULT; A = 32'd6; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b1; #1;
    m_hi = 32'd0; m_lo = 32'd0;
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      fails++; $display("FAIL reset_mid_immediate got %b/%h/%h want 0/0/0", busy, HI, LO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        fails++; $display("FAIL reset_mid_idle[%0d] got %b/%h/%h want 0/0/0", i, busy, HI, LO);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    bit done;
    int v0;
    v0 = viol_cnt;
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; md_op = MD_MTLO; A = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    n = 4; done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin done = 1; break; end
      n++;
    end
    model_apply(MD_DIV, 32'd100, 32'd7);
    tests++;
    if (!done || n != 10) begin
      fails++; $display("FAIL busy_violation_cycles got %0d want 10", done ? n : -1);
    end
    tests++;
    if (LO !== m_lo || HI !== m_hi) begin
      fails++; $display("FAIL busy_violation_hilo got %h/%h want %h/%h", HI, LO, m_hi, m_lo);
    end
    tests++;
    if (viol_cnt - v0 != 1) begin
      fails++; $display("FAIL violation_flagged got %0d want 1", viol_cnt - v0);
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_checked($sformatf("rand%0d_op%0d", i, op), op, a, b);
      md_op = MD_MFHI; #1;
      tests++;
      if (md_out !== m_hi) begin
        fails++; $display("FAIL rand%0d_mfhi got %h want %h", i, md_out, m_hi);
      end
      md_op = MD_MFLO; #1;
      tests++;
      if (md_out !== m_lo) begin
        fails++; $display("FAIL rand%0d_mflo got %h want %h", i, md_out, m_lo);
      end
      md_op = MD_NONE;
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero_and_mf;
    test_reset_mid;
    test_start_while_busy;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
